multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the phase-3 MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable.
- Drives ExtOp to the immediate sign/zero extender: sign-extend for lw/sw/beq/addi, zero-extend for andi/ori.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- zero  in  1  ALU zero flag; used only in BRANCH.
- mem_ready  in  1  memory-done handshake; used only with MEM_WAIT_EN.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero=1.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = ext, 11 = ext<<2.
- ALUOp  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- state  out  4  current state code (debug).
- illegal  out  1  one-cycle pulse on an unknown opcode.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: asynchronous; rst_n=0 forces state=FETCH (0), retired=0 and illegal=0.
- While rst_n=0, all strobes are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
- All selects and ALUOp read 0 in reset; ExtOp=1 in reset.
- Reset may be asserted mid-instruction: no partial write completes after rst_n falls.
- Outputs are Moore-decoded from state; the only exception is the rst_n gating above.
- States (code) and actions:
  - FETCH(0): MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, PCWrite. Next state DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=000, ExtOp=1.
  - DECODE transitions on opcode:
    - 000000 (R-type) -> EXEC.
    - 100011 (lw) / 101011 (sw) -> MEM_ADDR.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - 001000 (addi) / 001100 (andi) / 001101 (ori) -> IMM_EX.
    - any other opcode -> FETCH; illegal=1 for that cycle; retired does not change.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000. Next: lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD(3): MemRead, IorD=1. Next MEM_WB.
  - MEM_WB(4): RegWrite, MemtoReg=1, RegDst=0. Next FETCH.
  - MEM_WR(5): MemWrite, IorD=1. Next FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next R_WB.
  - R_WB(7): RegWrite, RegDst=1, MemtoReg=0. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond, PCSource=01. Next FETCH.
  - JUMP(9): PCWrite, PCSource=10. Next FETCH.
  - IMM_EX(10): ALUSrcA=1, ALUSrcB=10.
    - addi: ExtOp=1, ALUOp=000.
    - andi: ExtOp=0, ALUOp=011.
    - ori: ExtOp=0, ALUOp=100.
    - Next IMM_WB.
  - IMM_WB(11): RegWrite, RegDst=0, MemtoReg=0. Next FETCH.
- Opcode is latched into an internal register in DECODE; IMM_EX and MEM_ADDR use the latched value, not the live opcode.
- Unlisted outputs in any state are 0, except ExtOp, which defaults to 1.
- retired increments by 1 on the final-state edge of each legal instruction (MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, IMM_WB). It wraps from 2^CNT_W-1 to 0.
- Cycle counts: lw 5; sw, R-type, addi, andi, ori 4; beq, j 3.
- Unused state codes 12-15 -> FETCH on the next edge; illegal is not pulsed.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: FETCH, MEM_RD and MEM_WR hold their state and outputs until mem_ready=1 on a rising edge, then advance.
  - In FETCH, PCWrite is asserted only in the cycle where mem_ready=1, so PC increments exactly once.
- Undefined: mem_ready is ignored; these three states last exactly 1 cycle.

Test Plan:
- Reset: rst_n=0 mid-MEM_WR -> MemWrite drops to 0 immediately; state=0, retired=0. Release -> FETCH with MemRead=1 and IRWrite=1.
- lw: opcode=100011 -> state sequence 0,1,2,3,4,0; MEM_ADDR shows ExtOp=1, ALUSrcB=10; MEM_WB shows RegWrite=1, MemtoReg=1; retired goes 0->1.
- andi then ori: opcode=001100 then 001101 -> IMM_EX shows ExtOp=0 with ALUOp=011, then ALUOp=100; each takes 4 cycles; retired=2.
- beq: opcode=000100, zero=1 -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=001; 3 cycles. Repeat with zero=0 -> same outputs (PC gating is in the datapath).
- Illegal: opcode=111111 -> illegal pulses for exactly 1 cycle in DECODE; next state 0; retired unchanged.
- MEM_WAIT_EN: sw with mem_ready=0 for 3 cycles in MEM_WR -> MemWrite held for 4 cycles; exits on the mem_ready=1 edge. FETCH with 2 wait cycles -> PCWrite asserted in exactly 1 cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the datapath, drives all selects/strobes,
// counts retired instructions. Optional `MEM_WAIT_EN` stalls memory states on mem_ready.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    state_t     st, st_nx;
    logic [5:0] op_q;
    logic       retire;
    logic       mem_go;

    // zero is consumed by the datapath's PC gating, not by the controller
    logic unused_in;
    assign unused_in = ^{zero, mem_ready};

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_FETCH;
            op_q    <= 6'd0;
            retired <= '0;
        end else begin
            st <= st_nx;
            if (st == S_DECODE)
                op_q <= opcode;
            if (retire)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state = st;

    always_comb begin
        st_nx       = st;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        ExtOp       = 1'b1;
        illegal     = 1'b0;
        retire      = 1'b0;

        case (st)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                // PC advances only on the cycle the fetch completes
                PCWrite = mem_go;
                if (mem_go)
                    st_nx = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R:                      st_nx = S_EXEC;
                    OP_LW, OP_SW:              st_nx = S_MEM_ADDR;
                    OP_BEQ:                    st_nx = S_BRANCH;
                    OP_J:                      st_nx = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  st_nx = S_IMM_EX;
                    default: begin
                        st_nx   = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                st_nx   = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_go)
                    st_nx = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                st_nx    = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_go) begin
                    retire = 1'b1;
                    st_nx  = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                st_nx   = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                st_nx    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                st_nx       = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                st_nx    = S_FETCH;
            end
            S_IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // latched opcode: the IR may already be changing under us
                case (op_q)
                    OP_ANDI: begin ExtOp = 1'b0; ALUOp = 3'b011; end
                    OP_ORI:  begin ExtOp = 1'b0; ALUOp = 3'b100; end
                    default: begin ExtOp = 1'b1; ALUOp = 3'b000; end
                endcase
                st_nx = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                st_nx    = S_FETCH;
            end
            default: st_nx = S_FETCH;
        endcase

        // reset gates outputs immediately so no partial write completes
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 3'b000;
            PCSource    = 2'b00;
            ExtOp       = 1'b1;
            illegal     = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs queued per instruction.
module tb_multicycle_ctrl;

    localparam int CW = 3;

    logic          clk, rst_n, zero, mem_ready;
    logic [5:0]    opcode;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, illegal;
    logic [1:0]    ALUSrcB, PCSource;
    logic [2:0]    ALUOp;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ExtOp(ExtOp), .state(state), .illegal(illegal),
        .retired(retired)
    );

    typedef struct packed {
        logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
        logic MemtoReg, RegDst, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUOp;
        logic [1:0] PCSource;
        logic ExtOp;
        logic [3:0] state;
        logic illegal;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  mr;
    } rec_t;

    outs_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, state, illegal};

    rec_t          q[$];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_ret = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000, 6'b001100, 6'b001101};
    endfunction

    // expected outputs straight from the state action table
    function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic mr);
        outs_t o;
        o = '0;
        o.ExtOp = 1'b1;
        o.state = st[3:0];
        case (st)
            0:  begin o.MemRead = 1; o.IRWrite = 1; o.ALUSrcB = 2'b01; o.PCWrite = mr; end
            1:  begin o.ALUSrcB = 2'b11; o.illegal = !legal(op); end
            2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            3:  begin o.MemRead = 1; o.IorD = 1; end
            4:  begin o.RegWrite = 1; o.MemtoReg = 1; end
            5:  begin o.MemWrite = 1; o.IorD = 1; end
            6:  begin o.ALUSrcA = 1; o.ALUOp = 3'b010; end
            7:  begin o.RegWrite = 1; o.RegDst = 1; end
            8:  begin o.ALUSrcA = 1; o.ALUOp = 3'b001; o.PCWriteCond = 1; o.PCSource = 2'b01; end
            9:  begin o.PCWrite = 1; o.PCSource = 2'b10; end
            10: begin
                o.ALUSrcA = 1; o.ALUSrcB = 2'b10;
                if (op == 6'b001100)      begin o.ExtOp = 0; o.ALUOp = 3'b011; end
                else if (op == 6'b001101) begin o.ExtOp = 0; o.ALUOp = 3'b100; end
            end
            11: o.RegWrite = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t reset_out();
        outs_t o;
        o = '0;
        o.ExtOp = 1'b1;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input int st, input logic [5:0] op, input logic mr);
        rec_t r;
        r.o  = exp_out(st, op, mr);
        r.mr = mr;
        q.push_back(r);
    endtask

    task automatic push_seq(input logic [5:0] op);
        push(0, op, 1'b1);
        push(1, op, 1'b1);
        case (op)
            6'b100011: begin push(2, op, 1'b1); push(3, op, 1'b1); push(4, op, 1'b1); end
            6'b101011: begin push(2, op, 1'b1); push(5, op, 1'b1); end
            6'b000000: begin push(6, op, 1'b1); push(7, op, 1'b1); end
            6'b000100: push(8, op, 1'b1);
            6'b000010: push(9, op, 1'b1);
            6'b001000, 6'b001100, 6'b001101: begin push(10, op, 1'b1); push(11, op, 1'b1); end
            default: ;
        endcase
    endtask

    // called at a falling edge: apply the cycle's mem_ready, then compare
    task automatic step(input string tag);
        rec_t r;
        r = q.pop_front();
        mem_ready = r.mr;
        #1;
        chk($sformatf("%s st%0d", tag, r.o.state), 32'(obs), 32'(r.o));
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            step(tag);
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
        opcode = op;
        zero   = z;
        push_seq(op);
        drain(tag);
        if (legal(op))
            exp_ret = exp_ret + 1'b1;
        chk({tag, " retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk("reset outs", 32'(obs), 32'(reset_out()));
        chk("reset retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset asserted while MEM_WR is driving MemWrite
        opcode = 6'b101011;
        push_seq(6'b101011);
        repeat (3) begin
            step("sw_rst");
            @(negedge clk);
        end
        step("sw_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst outs", 32'(obs), 32'(reset_out()));
        chk("midrst retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("lw",    6'b100011, 1'b0);
        run_instr("andi",  6'b001100, 1'b0);
        run_instr("ori",   6'b001101, 1'b0);
        run_instr("beq_z1", 6'b000100, 1'b1);
        run_instr("beq_z0", 6'b000100, 1'b0);
        run_instr("illeg", 6'b111111, 1'b0);
        run_instr("j",     6'b000010, 1'b0);
        run_instr("rtype", 6'b000000, 1'b0);
        run_instr("addi",  6'b001000, 1'b0);
        run_instr("sw",    6'b101011, 1'b0);
        // 3-bit counter: nine retirements wrap past 7 to 1
        run_instr("illeg2", 6'b010101, 1'b0);

`ifdef MEM_WAIT_EN
        // two stalled fetch cycles, then sw stalled three cycles in MEM_WR
        opcode = 6'b101011;
        push(0, opcode, 1'b0);
        push(0, opcode, 1'b0);
        push(0, opcode, 1'b1);
        push(1, opcode, 1'b1);
        push(2, opcode, 1'b1);
        push(5, opcode, 1'b0);
        push(5, opcode, 1'b0);
        push(5, opcode, 1'b0);
        push(5, opcode, 1'b1);
        drain("sw_wait");
        exp_ret = exp_ret + 1'b1;
        chk("sw_wait retired", 32'(retired), 32'(exp_ret));
        mem_ready = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
